// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. A WIDTH-bit operand pair plus carry-in is captured over a
//   valid/ready handshake, then pushed LSB first through a single one-bit
//   full-adder cell, one bit per clock. The result (sum, carry-out, signed
//   overflow) is presented over a second valid/ready handshake and held until
//   the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  result valid (DONE only)
//   out_ready  consumer takes result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------

// One-bit full-adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             fa_s, fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shift;

  fulladder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_shift;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= fa_co;
          if (last_bit) begin
            // carry_q is the carry into the MSB, fa_co the carry out of it.
            cout_q <= fa_co;
            ovf_q  <= carry_q ^ fa_co;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;  // DONE: result held stable
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, y, input logic c);
    int unsigned full;
    logic [W-1:0] s;
    logic co, ov;
    full = int'(x) + int'(y) + int'(c);
    s    = W'(full % (1 << W));
    co   = (full >= (1 << W));
    ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle; the next edge is the accept edge (IDLE).
  task automatic start_op(input logic [W-1:0] x, y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] x, y, input logic c);
    logic [W+1:0] e;
    e = ref_add(x, y, c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(sum),  32'(e[W-1:0]));
    chk({tag, "_cout"},  32'(cout), 32'(e[W]));
    chk({tag, "_ovf"},   32'(ovf),  32'(e[W+1]));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] x, y, input logic c);
    int cyc;
    start_op(x, y, c);
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(W));
    chk_result(tag, x, y, c);
    release_result(tag);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    // Directed arithmetic cases.
    full_op("t3c5a", 8'h3C, 8'h5A, 1'b0);
    full_op("tff01", 8'hFF, 8'h01, 1'b0);
    full_op("tffff", 8'hFF, 8'hFF, 1'b1);

    // Backpressure plus in-flight input changes.
    start_op(8'h12, 8'h34, 1'b0);
    tick(); tick();
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_done(cyc);
    chk("bp_latency", 32'(cyc + 3), 32'(W));
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_sum",      32'(sum),       32'h46);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    chk_result("bp", 8'h12, 8'h34, 1'b0);
    release_result("bp");

    // Reset after three RUN cycles.
    start_op(8'h77, 8'h11, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    full_op("t8080", 8'h80, 8'h80, 1'b0);

    // Reset while holding a result in DONE.
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(cyc);
    chk("donerst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_out_valid", 32'(out_valid), 32'd0);
    chk("donerst_in_ready",  32'(in_ready),  32'd1);

    // in_valid held high: second pair is only taken once back in IDLE.
    a = 8'h9C; b = 8'h27; cin = 1'b1; in_valid = 1'b1;
    tick();
    a = 8'h40; b = 8'h41; cin = 1'b0;
    chk("b2b_run_in_ready", 32'(in_ready), 32'd0);
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'(W));
    chk("b2b_done_in_ready", 32'(in_ready), 32'd0);
    chk_result("b2b1", 8'h9C, 8'h27, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b2_in_ready", 32'(in_ready), 32'd0);
    wait_done(cyc);
    chk("b2b2_latency", 32'(cyc), 32'(W));
    chk_result("b2b2", 8'h40, 8'h41, 1'b0);
    release_result("b2b2");

    // Randomized operations with random backpressure.
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      start_op(ra, rb, rc);
      wait_done(cyc);
      chk("rnd_latency", 32'(cyc), 32'(W));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      chk_result("rnd", ra, rb, rc);
      release_result("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that feeds the team's one-bit full-adder cell one operand bit per clock, LSB first.
- Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake.
- Returns a WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Serves as the area-minimal alternative to a ripple adder in the datapath labs.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=IDLE, bit counter<=0, carry reg<=0.
  - Operand shift regs, sum<=0, cout<=0, ovf<=0.
  - Outputs after reset: in_ready=1, out_valid=0.
  - Reset overrides all other activity, including mid-RUN and DONE; any in-flight result is discarded.
- Bit slice: one instance of the existing fulladder cell.
  - Inputs: a_sh[0], b_sh[0], carry reg.
  - Outputs: S, Cout. Carry reg and MSB of sum are the only consumers of these outputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: a_sh<=a, b_sh<=b, carry<=cin, counter<=0, state<=RUN.
  - Otherwise hold.
- RUN, each cycle:
  - sum<={S, sum[WIDTH-1:1]}.
  - a_sh, b_sh shift right by 1.
  - carry<=Cout, counter<=counter+1.
  - When counter==WIDTH-1 (last bit): cout<=Cout, ovf<=carry^Cout, state<=DONE.
  - in_ready=0, out_valid=0.
  - in_valid, a, b, cin are ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout, ovf held stable while out_ready=0 (no drop, no change).
  - On out_ready=1: state<=IDLE.
- Latency:
  - Accept edge E0; out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
  - Minimum per-operation period is WIDTH+2 cycles; no overlap of consecutive operations.
- Validity window: sum/cout/ovf are only meaningful while out_valid=1. Bench must not check them otherwise.
- WIDTH=1: RUN lasts one cycle; ovf = cin XOR cout.
- Counter width: $clog2(WIDTH+1). The counter never exceeds WIDTH-1.
- Arithmetic:
  - sum = (a+b+cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full-precision sum.
  - ovf set iff a and b share a sign bit and sum's sign bit differs.

Test Plan (WIDTH=8):
- a=0x3C, b=0x5A, cin=0 → sum=0x96, cout=0, ovf=1; out_valid high exactly 8 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- Backpressure, after a=0x12, b=0x34 completes:
  - out_ready=0 for 5 cycles → out_valid stays 1, sum=0x46 stable, in_ready=0.
  - out_ready=1 → next cycle out_valid=0, in_ready=1.
- In-flight change: change a, b, cin and pulse in_valid during RUN → result unaffected (original 0x12+0x34=0x46).
- Reset mid-op:
  - Assert rst after 3 RUN cycles → next cycle in_ready=1, out_valid=0.
  - Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1.
- Reset in DONE with out_ready=0 → out_valid=0 next cycle; no result delivered. Then an operation with in_valid held high continuously back-to-back → in_ready deasserts during RUN/DONE and the second operand pair is accepted only in IDLE.
